// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into ALU operands and control,
// held in a single valid/ready pipeline register in front of execute.
module alu_issue_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs1_data,
    input  logic [31:0]      in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      operand_a,
    output logic [31:0]      operand_b,
    output logic [3:0]       alu_control,
    output logic             out_branch,
    output logic             out_take_on_zero,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_u, shamt;

    logic [31:0] dec_a, dec_b;
    alu_op_e     dec_op;
    logic        dec_br, dec_toz, dec_ill;

    logic             valid_q, valid_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             br_q, br_d, toz_q, toz_d, ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign shamt  = {27'b0, in_instr[24:20]};

    always_comb begin
        dec_a   = in_rs1_data;
        dec_b   = imm_i;
        dec_op  = ALU_ADD;
        dec_br  = 1'b0;
        dec_toz = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_b = in_rs2_data;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = ALU_ADD;
                        3'b001:  dec_op = ALU_SLL;
                        3'b010:  dec_op = ALU_SLT;
                        3'b011:  dec_op = ALU_SLTU;
                        3'b100:  dec_op = ALU_XOR;
                        3'b101:  dec_op = ALU_SRL;
                        3'b110:  dec_op = ALU_OR;
                        default: dec_op = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_op = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_b   = shamt;
                        dec_op  = ALU_SLL;
                        dec_ill = (funct7 != 7'b0000000);
                    end
                    default: begin
                        dec_b = shamt;
                        if (funct7 == 7'b0000000)      dec_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec_op = ALU_SRA;
                        else                           dec_ill = 1'b1;
                    end
                endcase
            end
            7'b0110111: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            7'b0010111: begin
                dec_a = in_pc;
                dec_b = imm_u;
            end
            7'b0000011: dec_b = imm_i;
            7'b0100011: dec_b = imm_s;
            7'b1100111: dec_ill = (funct3 != 3'b000);
            7'b1100011: begin
                dec_b  = in_rs2_data;
                dec_br = 1'b1;
                case (funct3)
                    3'b000: begin dec_op = ALU_SUB;  dec_toz = 1'b1; end
                    3'b001: begin dec_op = ALU_SUB;  dec_toz = 1'b0; end
                    3'b100: begin dec_op = ALU_SLT;  dec_toz = 1'b0; end
                    3'b101: begin dec_op = ALU_SLT;  dec_toz = 1'b1; end
                    3'b110: begin dec_op = ALU_SLTU; dec_toz = 1'b0; end
                    3'b111: begin dec_op = ALU_SLTU; dec_toz = 1'b1; end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal ops still issue, but as a harmless ADD 0+0 with no branch hints.
        if (dec_ill) begin
            dec_a   = '0;
            dec_b   = '0;
            dec_op  = ALU_ADD;
            dec_br  = 1'b0;
            dec_toz = 1'b0;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        br_d    = br_q;
        toz_d   = toz_q;
        ill_d   = ill_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = dec_a;
            b_d     = dec_b;
            ctrl_d  = dec_op;
            br_d    = dec_br;
            toz_d   = dec_toz;
            ill_d   = dec_ill;
            if (dec_ill && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            br_q    <= 1'b0;
            toz_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            br_q    <= br_d;
            toz_q   <= toz_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid        = valid_q;
    assign operand_a        = a_q;
    assign operand_b        = b_q;
    assign alu_control      = ctrl_q;
    assign out_branch       = br_q;
    assign out_take_on_zero = toz_q;
    assign out_illegal      = ill_q;
    assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: expected decodes are queued on accept and compared when issued.
module tb_alu_issue_stage;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      operand_a, operand_b;
    logic [3:0]       alu_control;
    logic             out_branch, out_take_on_zero, out_illegal;
    logic [CNT_W-1:0] illegal_count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic        br;
        logic        toz;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .in_rs1_data      (in_rs1_data),
        .in_rs2_data      (in_rs2_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .alu_control      (alu_control),
        .out_branch       (out_branch),
        .out_take_on_zero (out_take_on_zero),
        .out_illegal      (out_illegal),
        .illegal_count    (illegal_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'h06400093, 32'h0, 32'h5, 32'h0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({out_valid, operand_a, operand_b, alu_control, out_branch, out_take_on_zero,
             out_illegal, illegal_count, in_ready} !== {1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 8'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset: v=%b a=%h b=%h c=%0d br=%b toz=%b ill=%b cnt=%0d rdy=%b, required all zero with rdy=1",
                     out_valid, operand_a, operand_b, alu_control, out_branch, out_take_on_zero,
                     out_illegal, illegal_count, in_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] instr_t[9]  = '{32'h06400093, 32'h402081B3, 32'h4030D093, 32'h00209063,
                                     32'h0020D063, 32'h123452B7, 32'h12345297, 32'h0020E1B3, 32'h000100E7};
        logic [31:0] pc_t[9]     = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0};
        logic [31:0] rs1_t[9]    = '{32'h5, 32'h7, 32'h80000000, 32'h12, 32'h13, 32'hAAAA, 32'hBBBB, 32'hF0, 32'h400};
        logic [31:0] rs2_t[9]    = '{32'h9, 32'h7, 32'h55, 32'h34, 32'h35, 32'hCCCC, 32'hDDDD, 32'h0F, 32'h99};
        exp_t        ex_t[9]     = '{
            '{32'h5,  32'd100, 4'd0, 1'b0, 1'b0, 1'b0},
            '{32'h7,  32'h7,   4'd1, 1'b0, 1'b0, 1'b0},
            '{32'h80000000, 32'h3, 4'd7, 1'b0, 1'b0, 1'b0},
            '{32'h12, 32'h34,  4'd1, 1'b1, 1'b0, 1'b0},
            '{32'h13, 32'h35,  4'd8, 1'b1, 1'b1, 1'b0},
            '{32'h0,  32'h12345000, 4'd0, 1'b0, 1'b0, 1'b0},
            '{32'h100, 32'h12345000, 4'd0, 1'b0, 1'b0, 1'b0},
            '{32'hF0, 32'h0F,  4'd3, 1'b0, 1'b0, 1'b0},
            '{32'h400, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0}};
        string       nm_t[9]     = '{"addi", "sub", "srai", "bne", "bge", "lui", "auipc", "or", "jalr"};
        exp_t        e;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(instr_t[i], pc_t[i], rs1_t[i], rs2_t[i]);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_in_ready: got %b, required 1", nm_t[i], in_ready);
            end
            sb.push_back(ex_t[i]);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL %s: scoreboard empty", nm_t[i]);
            end else begin
                e = sb.pop_front();
                if ({out_valid, operand_a, operand_b, alu_control, out_branch, out_take_on_zero, out_illegal}
                    !== {1'b1, e.a, e.b, e.c, e.br, e.toz, e.ill}) begin
                    n_fail++;
                    $display("FAIL %s: got v=%b a=%h b=%h c=%0d br=%b toz=%b ill=%b, required v=1 a=%h b=%h c=%0d br=%b toz=%b ill=%b",
                             nm_t[i], out_valid, operand_a, operand_b, alu_control, out_branch,
                             out_take_on_zero, out_illegal, e.a, e.b, e.c, e.br, e.toz, e.ill);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] instr_t[4] = '{32'hFE20AE23, 32'hFFF12083, 32'h0020C1B3, 32'h40000113};
        exp_t        ex_t[4]    = '{
            '{32'h1000, 32'hFFFFFFFC, 4'd0, 1'b0, 1'b0, 1'b0},
            '{32'h2000, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b0, 1'b0},
            '{32'h3000, 32'h3333,     4'd4, 1'b0, 1'b0, 1'b0},
            '{32'h4000, 32'h00000400, 4'd0, 1'b0, 1'b0, 1'b0}};
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(instr_t[i], 32'h0, 32'h1000 * (i + 1), 32'h1111 * (i + 1));
            sb.push_back(ex_t[i]);
            @(posedge clk);
            #1;
            n_tests++;
            e = sb.pop_front();
            if ({out_valid, operand_a, operand_b, alu_control, out_illegal} !== {1'b1, e.a, e.b, e.c, e.ill}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b a=%h b=%h c=%0d ill=%b, required v=1 a=%h b=%h c=%0d ill=%b",
                         i, out_valid, operand_a, operand_b, alu_control, out_illegal, e.a, e.b, e.c, e.ill);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: got v=%b pending=%0d, required v=0 pending=0", out_valid, sb.size());
        end
    endtask

    task automatic test_illegal_saturation();
        int unsigned exp_cnt = 0;
        logic [31:0] ins;
        exp_t        e;
        out_ready = 1'b1;
        for (int i = 0; i < 302; i++) begin
            ins = (i == 0) ? 32'h40009093 : (i == 1) ? 32'h0020A063 : 32'hFFFFFFFF;
            drive(ins, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D);
            sb.push_back('{32'h0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1});
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            @(posedge clk);
            #1;
            n_tests++;
            e = sb.pop_front();
            if ({out_valid, operand_a, operand_b, alu_control, out_branch, out_take_on_zero, out_illegal, illegal_count}
                !== {1'b1, e.a, e.b, e.c, e.br, e.toz, e.ill, exp_cnt[7:0]}) begin
                n_fail++;
                $display("FAIL illegal_%0d: got v=%b a=%h b=%h c=%0d br=%b toz=%b ill=%b cnt=%0d, required v=1 a=0 b=0 c=0 br=0 toz=0 ill=1 cnt=%0d",
                         i, out_valid, operand_a, operand_b, alu_control, out_branch, out_take_on_zero,
                         out_illegal, illegal_count, exp_cnt);
            end
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (illegal_count !== 8'd255 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_hold: got cnt=%0d v=%b, required cnt=255 v=0", illegal_count, out_valid);
        end
    endtask

    task automatic test_backpressure_reset();
        exp_t e;
        out_ready = 1'b0;
        drive(32'h002081B3, 32'h0, 32'h11, 32'h22);
        sb.push_back('{32'h11, 32'h22, 4'd0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        drive(32'h0020C1B3, 32'h0, 32'h33, 32'h44);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            e = sb[0];
            if ({in_ready, out_valid, operand_a, operand_b, alu_control, out_illegal, illegal_count}
                !== {1'b0, 1'b1, e.a, e.b, e.c, e.ill, 8'd255}) begin
                n_fail++;
                $display("FAIL stall_%0d: got rdy=%b v=%b a=%h b=%h c=%0d ill=%b cnt=%0d, required rdy=0 v=1 a=%h b=%h c=%0d ill=0 cnt=255",
                         i, in_ready, out_valid, operand_a, operand_b, alu_control, out_illegal,
                         illegal_count, e.a, e.b, e.c);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        e = sb.pop_front();
        if ({in_ready, operand_a, operand_b, alu_control} !== {1'b1, e.a, e.b, e.c}) begin
            n_fail++;
            $display("FAIL release: got rdy=%b a=%h b=%h c=%0d, required rdy=1 a=%h b=%h c=%0d",
                     in_ready, operand_a, operand_b, alu_control, e.a, e.b, e.c);
        end
        sb.push_back('{32'h33, 32'h44, 4'd4, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(32'h06400093, 32'h0, 32'h77, 32'h88);
        n_tests++;
        e = sb[0];
        if ({out_valid, operand_a, operand_b, alu_control} !== {1'b1, e.a, e.b, e.c}) begin
            n_fail++;
            $display("FAIL after_release: got v=%b a=%h b=%h c=%0d, required v=1 a=%h b=%h c=%0d",
                     out_valid, operand_a, operand_b, alu_control, e.a, e.b, e.c);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        n_tests++;
        if ({out_valid, operand_a, operand_b, alu_control, out_illegal, illegal_count}
            !== {1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 8'h0}) begin
            n_fail++;
            $display("FAIL stall_reset: got v=%b a=%h b=%h c=%0d ill=%b cnt=%0d, required all zero",
                     out_valid, operand_a, operand_b, alu_control, out_illegal, illegal_count);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_illegal_saturation();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered decode/issue stage that drives the ALU.
- Accepts an RV32I instruction with its PC and register-file read data, then decodes opcode/funct3/funct7.
- Produces operand_a, operand_b and the 4-bit alu_control, plus branch-resolution hints that are interpreted against the ALU zero_flag.
- One pipeline register with valid/ready handshake on both sides; sits between register read and execute.

Parameters:
CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept this cycle
in_instr  input  32  instruction word
in_pc  input  32  instruction address
in_rs1_data  input  32  rs1 register value
in_rs2_data  input  32  rs2 register value
out_valid  output  1  issued operation valid
out_ready  input  1  execute stage accepts
operand_a  output  32  ALU operand A
operand_b  output  32  ALU operand B
alu_control  output  4  ALU op: ADD=0,SUB=1,AND=2,OR=3,XOR=4,SLL=5,SRL=6,SRA=7,SLT=8,SLTU=9
out_branch  output  1  operation is a conditional branch compare
out_take_on_zero  output  1  branch taken when ALU zero_flag==1 (else taken when zero_flag==0)
out_illegal  output  1  instruction failed decode
illegal_count  output  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (rst=1 at clk edge): all outputs 0, including out_valid, operand_a/b, alu_control, flags and illegal_count. Reset overrides any transfer in progress; the held entry is discarded.
- in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready.
- Latency: accepted at edge N, visible with out_valid=1 after edge N. Full throughput (1 op/cycle) when out_ready held high.
- At an edge with accept: register the new decode, out_valid=1.
- At an edge with out_valid && out_ready and no accept: out_valid=0. Data outputs hold their last value.
- While out_valid && !out_ready: all outputs stable.
- Immediates:
  - I = sext(instr[31:20]).
  - S = sext({instr[31:25],instr[11:7]}).
  - U = {instr[31:12],12'b0}.
  - shamt = zero-extended instr[24:20].
- Decode by opcode instr[6:0]:
  - OP 0110011: a=rs1, b=rs2. funct7=0000000 with funct3 000..111 gives ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND. funct7=0100000 with funct3 000 gives SUB, funct3 101 gives SRA. Anything else is illegal.
  - OP-IMM 0010011: a=rs1, b=I. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND. Shifts use b=shamt: 001 requires funct7=0 (SLL); 101 with funct7=0 gives SRL, with 0100000 gives SRA. Other funct7 on a shift is illegal.
  - LUI 0110111: a=0, b=U, ADD.
  - AUIPC 0010111: a=in_pc, b=U, ADD.
  - LOAD 0000011: a=rs1, b=I, ADD.
  - STORE 0100011: a=rs1, b=S, ADD.
  - JALR 1100111 (funct3 must be 000): a=rs1, b=I, ADD.
  - BRANCH 1100011: a=rs1, b=rs2, out_branch=1. BEQ 000: SUB, take_on_zero=1. BNE 001: SUB, 0. BLT 100: SLT, 0. BGE 101: SLT, 1. BLTU 110: SLTU, 0. BGEU 111: SLTU, 1. funct3 010/011 is illegal.
- Any other opcode is illegal.
- Illegal decode: out_illegal=1, operand_a=0, operand_b=0, alu_control=ADD, out_branch=0, out_take_on_zero=0. The op is still issued with out_valid=1.
- illegal_count increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W-1. It is not cleared by consumption.
- out_branch and out_take_on_zero are 0 for every non-branch op.

Test Plan:
- ADDI x1,x0,100 (0x06400093), rs1_data=5 -> next cycle out_valid=1, operand_a=5, operand_b=100, alu_control=0, out_illegal=0.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=7 -> alu_control=1, a=7, b=7. SRAI x1,x1,3 (0x4030D093), rs1=0x80000000 -> alu_control=7, b=3.
- BNE (0x00209063) -> alu_control=1, out_branch=1, take_on_zero=0. Same with funct3=101 (0x0020D063) -> alu_control=8, take_on_zero=1.
- LUI x5,0x12345 (0x123452B7) -> a=0, b=0x12345000, ADD. AUIPC with pc=0x100 -> a=0x100.
- 0xFFFFFFFF accepted 300 times (CNT_W=8) -> each op out_illegal=1, a=b=0, ADD. illegal_count reaches 255 and stays at 255.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, outputs frozen for 5 cycles. Then out_ready=1 with a new in_valid -> back-to-back transfers, no loss or duplication. Assert rst mid-stall -> out_valid=0 and illegal_count=0 next cycle.
